// File: rtl/pattern_scan_ctrl.sv
// Purpose: accepts parallel words, shifts them out MSB-first through an overlapping 4-bit pattern detector, returns hit count.
// Latency: out_valid rises WORD_W edges after the accepting edge; match_pulse is one cycle after the bit that completes a hit.
// Backpressure: one word in flight; in_ready only in IDLE, result held in DONE until out_ready.
module pattern_scan_ctrl #(
    parameter int         WORD_W  = 16,
    parameter logic [3:0] PATTERN = 4'b1011,
    parameter int         CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_chain,
    input  logic              abort,
    output logic              busy,
    output logic              match_pulse,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_SHIFT = 3'b010,
        S_DONE  = 3'b100
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WORD_W-1:0] r_shreg;
    logic [2:0]        r_hist;      // three most recent bits, newest in [0]
    logic [2:0]        r_fill;      // valid history depth, saturates at 4
    logic [BC_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]  r_match_cnt;
    logic              r_match_pulse;

    logic              w_bit;
    logic              w_accept;
    logic              w_shift;
    logic              w_last;
    logic              w_hit;

    assign w_bit    = r_shreg[WORD_W-1];
    assign w_accept = (r_state == S_IDLE) && in_valid && in_ready;
    // abort wins over the shift on the same edge, so that bit is never scored
    assign w_shift  = (r_state == S_SHIFT) && !abort;
    assign w_last   = (r_bit_cnt == LAST_BIT);
    // fill>=3 means three real history bits precede the current one
    assign w_hit    = w_shift && ({r_hist, w_bit} == PATTERN) && (r_fill >= 3'd3);

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state decode
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)      w_next_state = S_SHIFT;
            S_SHIFT: if (abort)         w_next_state = S_IDLE;
                     else if (w_last)   w_next_state = S_DONE;
            S_DONE:  if (out_ready)     w_next_state = S_IDLE;
            default:                    w_next_state = S_IDLE;
        endcase
    end

    // output decode; in_ready held low while reset is asserted
    always_comb begin
        in_ready    = (r_state == S_IDLE) && !reset;
        busy        = (r_state != S_IDLE);
        out_valid   = (r_state == S_DONE);
        out_count   = out_valid ? r_match_cnt : '0;
        match_pulse = r_match_pulse;
    end

    // datapath: capture, shift, history and hit counting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg       <= '0;
            r_hist        <= '0;
            r_fill        <= '0;
            r_bit_cnt     <= '0;
            r_match_cnt   <= '0;
            r_match_pulse <= 1'b0;
        end else begin
            r_match_pulse <= 1'b0;
            if (w_accept) begin
                r_shreg     <= in_data;
                r_bit_cnt   <= '0;
                r_match_cnt <= '0;
                if (!in_chain) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end
            end else if ((r_state == S_SHIFT) && abort) begin
                r_hist      <= '0;
                r_fill      <= '0;
                r_match_cnt <= '0;
            end else if (w_shift) begin
                r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
                r_hist    <= {r_hist[1:0], w_bit};
                r_fill    <= (r_fill >= 3'd4) ? 3'd4 : r_fill + 3'd1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_hit) begin
                    r_match_pulse <= 1'b1;
                    if (r_match_cnt != {CNT_W{1'b1}}) begin
                        r_match_cnt <= r_match_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
module tb_pattern_scan_ctrl;

    localparam int         W   = 16;
    localparam int         CW  = 5;
    localparam logic [3:0] PAT = 4'b1011;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_chain;
    logic          abort;
    logic          busy;
    logic          match_pulse;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;

    pattern_scan_ctrl #(.WORD_W(W), .PATTERN(PAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chain(in_chain),
        .abort(abort), .busy(busy), .match_pulse(match_pulse),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a word, 1 scanning, 2 result pending
    int  m_phase = 0;
    int  m_k     = 0;
    bit  m_hits[0:W];
    int  m_cnt   = 0;
    bit  m_pulse = 0;
    bit  hq[$];        // bit history carried between chained words
    bit  next_hq[$];
    int  cyc     = 0;
    int  acc_cyc = 0;
    bit  started = 0;

    // score a whole word at once from the bit stream history ++ word
    task automatic score_word(input logic [W-1:0] d);
        bit s[$];
        int h;
        int p;
        s = hq;
        h = hq.size();
        for (int i = W - 1; i >= 0; i--) s.push_back(d[i]);
        m_cnt = 0;
        for (int k = 1; k <= W; k++) begin
            p = h + k - 1;
            m_hits[k] = (p >= 3) && ({s[p-3], s[p-2], s[p-1], s[p]} == PAT);
            if (m_hits[k] && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        next_hq = s[s.size()-3 : s.size()-1];
    endtask

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (reset) begin
            m_phase = 0;
            m_pulse = 0;
            m_cnt   = 0;
            hq.delete();
        end else begin
            case (m_phase)
                0: begin
                    m_pulse = 0;
                    if (in_valid) begin
                        if (!in_chain) hq.delete();
                        score_word(in_data);
                        m_phase = 1;
                        m_k     = 0;
                        acc_cyc = cyc;
                    end
                end
                1: begin
                    if (abort) begin
                        m_phase = 0;
                        m_pulse = 0;
                        m_cnt   = 0;
                        hq.delete();
                    end else begin
                        m_k++;
                        m_pulse = m_hits[m_k];
                        if (m_k == W) begin
                            m_phase = 2;
                            hq = next_hq;
                        end
                    end
                end
                default: begin
                    m_pulse = 0;
                    if (out_ready) m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    int pulse_total   = 0;
    int last_pulse_off = -1;

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",    int'(in_ready),    int'(m_phase == 0 && !reset));
            chk("busy",        int'(busy),        int'(m_phase != 0));
            chk("out_valid",   int'(out_valid),   int'(m_phase == 2));
            chk("out_count",   int'(out_count),   (m_phase == 2) ? m_cnt : 0);
            chk("match_pulse", int'(match_pulse), int'(m_pulse));
            if (match_pulse) begin
                pulse_total++;
                last_pulse_off = cyc - acc_cyc;
            end
        end
    end

    // ---------------- directed helpers ----------------
    int pulse_base = 0;

    task automatic send(input logic [W-1:0] d, input logic ch);
        int n;
        n = 0;
        pulse_base = pulse_total;
        in_data  = d;
        in_chain = ch;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_timeout", n, (n < 50) ? n : 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic get_result(input int exp_cnt, input int exp_pulses);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("result_timeout", int'(n >= 60), 0);
        @(negedge clk); #1;
        chk("lit_out_count", int'(out_count), exp_cnt);
        chk("lit_model_cnt", m_cnt, exp_cnt);
        chk("lit_pulses", pulse_total - pulse_base, exp_pulses);
    endtask

    task automatic ack;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_chain = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_count", int'(out_count), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // single hit, pulse right after the 4th bit
        send(16'hB000, 1'b0);
        chk("t1_busy", int'(busy), 1);
        get_result(1, 1);
        chk("t1_pulse_pos", last_pulse_off, 4);
        ack();

        // overlapping hits
        send(16'hB6DB, 1'b0);
        get_result(5, 5);
        ack();

        // pattern spanning a word boundary
        send(16'h0001, 1'b0);
        get_result(0, 0);
        ack();
        send(16'h6000, 1'b1);
        get_result(1, 1);
        chk("t3_pulse_pos", last_pulse_off, 3);
        ack();
        send(16'h6000, 1'b0);
        get_result(0, 0);
        ack();

        send(16'hFFFF, 1'b0);
        get_result(0, 0);
        ack();
        send(16'h0000, 1'b0);
        get_result(0, 0);
        ack();

        // result held under backpressure while a new word waits
        send(16'hB6DB, 1'b0);
        get_result(5, 5);
        in_data = 16'hB000; in_chain = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t5_hold_valid", int'(out_valid), 1);
            chk("t5_hold_count", int'(out_count), 5);
            chk("t5_hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t5_idle_busy", int'(busy), 0);
        chk("t5_idle_in_ready", int'(in_ready), 1);
        pulse_base = pulse_total;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5_accept_busy", int'(busy), 1);
        get_result(1, 1);
        ack();

        // abort after the 8th bit
        send(16'hB6DB, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t6_abort_in_ready", int'(in_ready), 1);
        chk("t6_abort_busy", int'(busy), 0);
        chk("t6_abort_out_valid", int'(out_valid), 0);
        repeat (20) @(posedge clk);
        #1;

        // reset mid-scan
        send(16'hB6DB, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_pulse", int'(match_pulse), 0);
        chk("t6_rst_count", int'(out_count), 0);
        chk("t6_rst_in_ready", int'(in_ready), 0);
        reset = 1'b0;

        // randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = W'($urandom);
            in_chain  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            abort     = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
